text_ram_write_sched: RTL and testbench
=======================================

// Module: text_ram_write_sched
// PURPOSE
//  Schedules all writes into the character-display RAM for the VGA text terminal.
//  Arbitrates the single RAM write port between two byte sources: A (UART RX) and B (local echo/keyboard).
//  Tracks the cursor and interprets the newline code.
//  Sequences a full-screen clear that blanks every cell, then homes the cursor.
// PARAMETERS
//  ROWS      4     text rows in RAM; row index width RW = $clog2(ROWS)
//  COLS      32    text columns in RAM; column index width CW = $clog2(COLS)
//  HOME_ROW  1     cursor row after reset and after clear; cursor column is always 0
//  NL_CODE   8'h7E byte treated as newline; compared on bits [6:0] only
//  BLANK     8'h20 byte written to every cell during clear
// PORTS
//  clk        in   1   system clock, 100 MHz
//  reset      in   1   asynchronous, active-low reset
//  a_valid    in   1   source A has a byte
//  a_data     in   8   source A byte
//  a_ready    out  1   source A byte accepted when a_valid && a_ready
//  b_valid    in   1   source B has a byte
//  b_data     in   8   source B byte
//  b_ready    out  1   source B byte accepted when b_valid && b_ready
//  clr_req    in   1   one-cycle pulse: start a screen clear
//  ram_we     out  1   RAM write strobe
//  ram_row    out  RW  RAM write row
//  ram_col    out  CW  RAM write column
//  ram_wdata  out  8   RAM write data
//  cur_row    out  RW  current cursor row
//  cur_col    out  CW  current cursor column
//  busy       out  1   high in WRITE or CLEAR, or while a clear is pending
// BEHAVIOUR
//  Reset (async, reset==0):
//   - state = IDLE; ram_we = 0, ram_row/col = 0, ram_wdata = 0.
//   - cur_row = HOME_ROW, cur_col = 0; clr_pend = 0; rr_last = B (so A wins the first tie).
//   - Reset asserted mid-WRITE or mid-CLEAR aborts immediately; no further RAM writes.
//  States:
//   - IDLE:
//     - clr_req or clr_pend -> CLEAR. Both readies are held 0 that cycle.
//     - Otherwise, if any valid is high, exactly one ready goes high (combinational, same cycle).
//     - If only one source is valid, that source is granted.
//     - If both are valid, grant the source other than rr_last (round-robin).
//     - On handshake: latch the byte and the granted source id, update rr_last, go to WRITE.
//   - WRITE (exactly 1 cycle):
//     - If byte[6:0] == NL_CODE[6:0]:
//       - ram_we = 0;
//       - cur_col <= 0; cur_row <= row+1, wrapping ROWS-1 -> 0.
//     - Otherwise:
//       - ram_we = 1, ram_row/col = cursor, ram_wdata = byte;
//       - cursor advances col+1; at COLS-1: col <= 0 and row advances, with row wrapping as above.
//     - Next state -> IDLE. Sustained throughput is 1 byte per 2 cycles.
//   - CLEAR (ROWS*COLS cycles):
//     - Entry clears clr_pend.
//     - Sweep counter runs from 0 to ROWS*COLS-1, row-major.
//     - Each cycle: ram_we = 1, ram_wdata = BLANK, ram_row/col = counter.
//     - After the last cell: cursor <= (HOME_ROW, 0); state -> IDLE.
//  Ready rule: readies are 0 in WRITE and CLEAR; they never depend on ready of the other source.
//  Timing of ram_* outputs:
//   - ram_* are registered; a write lands 1 cycle after the handshake cycle.
//   - Cursor outputs show the post-write position in the cycle after the WRITE state.
//  Simultaneous events:
//   - clr_req during WRITE: sets clr_pend; the WRITE completes, then CLEAR starts.
//   - clr_req during CLEAR: ignored; the sweep is not restarted.
//   - clr_req together with valids in IDLE: clear wins; the bytes stay pending at their sources (valid held).
//  Sources must hold valid and data stable until accepted. Behaviour under a dropped valid is don't-care.
// TESTING
//  1. Reset release; A sends 'H','I' -> RAM (1,0)='H', (1,1)='I'; cursor (1,2); gap of 2 clks between writes.
//  2. Cursor at (1,31); A sends 'X' -> write to (1,31), cursor (2,0). At (3,31) the next byte wraps the cursor to (0,0).
//  3. A sends 8'h7E at (2,5) -> no ram_we; cursor (3,0). Also 8'hFE -> same (bit 7 ignored).
//  4. a_valid and b_valid held with distinct bytes -> grants alternate A,B,A,B; neither starves over 8 bytes.
//  5. clr_req pulse -> 128 consecutive ram_we cycles of 8'h20 at (0,0)..(3,31); readies 0 throughout; then cursor (1,0).
//  6. clr_req in WRITE cycle -> write completes, CLEAR follows. Reset at sweep cell 40 -> ram_we drops at once; cursor (1,0).

Source files
------------

// File: rtl/text_ram_write_sched.sv
// Write scheduler for the VGA text-terminal character RAM: arbitrates two byte
// sources onto one write port, tracks the cursor and sweeps a blank fill on clear.
module text_ram_write_sched #(
  parameter int         ROWS     = 4,
  parameter int         COLS     = 32,
  parameter int         HOME_ROW = 1,
  parameter logic [7:0] NL_CODE  = 8'h7E,
  parameter logic [7:0] BLANK    = 8'h20,
  localparam int        RW       = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int        CW       = (COLS > 1) ? $clog2(COLS) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          a_valid,
  input  logic [7:0]    a_data,
  output logic          a_ready,
  input  logic          b_valid,
  input  logic [7:0]    b_data,
  output logic          b_ready,
  input  logic          clr_req,
  output logic          ram_we,
  output logic [RW-1:0] ram_row,
  output logic [CW-1:0] ram_col,
  output logic [7:0]    ram_wdata,
  output logic [RW-1:0] cur_row,
  output logic [CW-1:0] cur_col,
  output logic          busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_CLEAR = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;

  logic          r_clr_pend;
  logic          r_last_b;
  logic          r_nl;
  logic [RW-1:0] r_cur_row;
  logic [CW-1:0] r_cur_col;
  logic          r_ram_we;
  logic [RW-1:0] r_ram_row;
  logic [CW-1:0] r_ram_col;
  logic [7:0]    r_ram_wdata;

  logic          w_a_ready;
  logic          w_b_ready;
  logic          w_grant_b;
  logic          w_accept;
  logic          w_clr_go;
  logic          w_sweep_last;
  logic          w_in_nl;
  logic [7:0]    w_in_byte;
  logic [RW-1:0] w_row_inc;

  assign w_clr_go     = clr_req | r_clr_pend;
  assign w_in_byte    = w_grant_b ? b_data : a_data;
  assign w_in_nl      = (w_in_byte[6:0] == NL_CODE[6:0]);
  assign w_row_inc    = (r_cur_row == RW'(ROWS - 1)) ? {RW{1'b0}} : r_cur_row + RW'(1);
  // The RAM address registers double as the clear sweep counter.
  assign w_sweep_last = (r_ram_row == RW'(ROWS - 1)) && (r_ram_col == CW'(COLS - 1));

  // Next-state, arbitration and ready generation.
  always_comb begin
    w_state_nxt = r_state;
    w_a_ready   = 1'b0;
    w_b_ready   = 1'b0;
    w_grant_b   = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_clr_go) begin
          w_state_nxt = ST_CLEAR;
        end else begin
          // On a tie the source that did not win last time is granted.
          w_grant_b = (a_valid && b_valid) ? ~r_last_b : b_valid;
          w_a_ready = a_valid & ~w_grant_b;
          w_b_ready = w_grant_b;
          w_accept  = a_valid | b_valid;
          if (w_accept) begin
            w_state_nxt = ST_WRITE;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      ST_WRITE: begin
        w_state_nxt = ST_IDLE;
      end
      ST_CLEAR: begin
        if (w_sweep_last) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_CLEAR;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Cursor, pending-clear flag and round-robin history.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_clr_pend <= 1'b0;
      r_last_b   <= 1'b1;
      r_nl       <= 1'b0;
      r_cur_row  <= RW'(HOME_ROW);
      r_cur_col  <= {CW{1'b0}};
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_clr_go) begin
            r_clr_pend <= 1'b0;
          end else if (w_accept) begin
            r_last_b <= w_grant_b;
            r_nl     <= w_in_nl;
          end
        end
        ST_WRITE: begin
          if (clr_req) begin
            r_clr_pend <= 1'b1;
          end
          if (r_nl || (r_cur_col == CW'(COLS - 1))) begin
            r_cur_col <= {CW{1'b0}};
            r_cur_row <= w_row_inc;
          end else begin
            r_cur_col <= r_cur_col + CW'(1);
          end
        end
        ST_CLEAR: begin
          if (w_sweep_last) begin
            r_cur_row <= RW'(HOME_ROW);
            r_cur_col <= {CW{1'b0}};
          end
        end
        default: begin
          r_clr_pend <= 1'b0;
        end
      endcase
    end
  end

  // Registered RAM write port: loaded on the handshake edge so the write
  // appears during WRITE, and stepped through every cell during CLEAR.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ram_we    <= 1'b0;
      r_ram_row   <= {RW{1'b0}};
      r_ram_col   <= {CW{1'b0}};
      r_ram_wdata <= 8'h00;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_clr_go) begin
            r_ram_we    <= 1'b1;
            r_ram_row   <= {RW{1'b0}};
            r_ram_col   <= {CW{1'b0}};
            r_ram_wdata <= BLANK;
          end else if (w_accept) begin
            r_ram_we    <= ~w_in_nl;
            r_ram_row   <= r_cur_row;
            r_ram_col   <= r_cur_col;
            r_ram_wdata <= w_in_byte;
          end else begin
            r_ram_we <= 1'b0;
          end
        end
        ST_WRITE: begin
          r_ram_we <= 1'b0;
        end
        ST_CLEAR: begin
          if (w_sweep_last) begin
            r_ram_we <= 1'b0;
          end else begin
            r_ram_we <= 1'b1;
            if (r_ram_col == CW'(COLS - 1)) begin
              r_ram_col <= {CW{1'b0}};
              r_ram_row <= r_ram_row + RW'(1);
            end else begin
              r_ram_col <= r_ram_col + CW'(1);
            end
          end
        end
        default: begin
          r_ram_we <= 1'b0;
        end
      endcase
    end
  end

  assign a_ready   = w_a_ready;
  assign b_ready   = w_b_ready;
  assign ram_we    = r_ram_we;
  assign ram_row   = r_ram_row;
  assign ram_col   = r_ram_col;
  assign ram_wdata = r_ram_wdata;
  assign cur_row   = r_cur_row;
  assign cur_col   = r_cur_col;
  assign busy      = (r_state != ST_IDLE) | r_clr_pend;

endmodule

// File: tb/tb_text_ram_write_sched.sv
// Directed/randomised bench for text_ram_write_sched with a cell-array cursor model
// and a shadow RAM rebuilt from the write port.
module tb_text_ram_write_sched;

  localparam int ROWS  = 4;
  localparam int COLS  = 32;
  localparam int HOME  = 1;
  localparam int CELLS = ROWS * COLS;

  logic       clk = 1'b0;
  logic       reset;
  logic       a_valid, b_valid, clr_req;
  logic [7:0] a_data, b_data;
  logic       a_ready, b_ready, ram_we, busy;
  logic [1:0] ram_row, cur_row;
  logic [4:0] ram_col, cur_col;
  logic [7:0] ram_wdata;

  int total = 0;
  int bad   = 0;
  int n_writes = 0;
  int m_row, m_col;
  bit m_last_b;
  logic [7:0] m_mem  [ROWS][COLS];
  logic [7:0] sh_mem [ROWS][COLS];

  text_ram_write_sched dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
    .clr_req(clr_req),
    .ram_we(ram_we), .ram_row(ram_row), .ram_col(ram_col), .ram_wdata(ram_wdata),
    .cur_row(cur_row), .cur_col(cur_col), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (reset === 1'b1 && ram_we === 1'b1) begin
      sh_mem[ram_row][ram_col] <= ram_wdata;
      n_writes <= n_writes + 1;
    end
  end

  initial begin
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        sh_mem[r][c] <= 8'h00;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] rnd_byte();
    logic [7:0] r;
    r = 8'($urandom_range(0, 255));
    if (r[6:0] == 7'h7E) r = 8'h41;
    return r;
  endfunction

  function automatic bit is_nl(input logic [7:0] d);
    return d[6:0] == 7'h7E;
  endfunction

  // Called at the negedge of the WRITE cycle of byte d.
  task automatic expect_write(input string tag, input logic [7:0] d);
    int lin;
    if (is_nl(d)) begin
      chk({tag, "_we"}, ram_we, 0);
      m_col = 0;
      m_row = (m_row + 1) % ROWS;
    end else begin
      chk({tag, "_we"}, ram_we, 1);
      chk({tag, "_row"}, ram_row, m_row);
      chk({tag, "_col"}, ram_col, m_col);
      chk({tag, "_data"}, ram_wdata, d);
      m_mem[m_row][m_col] = d;
      lin   = (m_row * COLS + m_col + 1) % CELLS;
      m_row = lin / COLS;
      m_col = lin % COLS;
    end
  endtask

  task automatic wait_ready(input bit use_b, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (use_b ? b_ready : a_ready) begin
        ok = 1'b1;
        return;
      end
    end
    chk("ready_timeout", use_b ? b_ready : a_ready, 1);
  endtask

  task automatic send(input bit use_b, input logic [7:0] d, input string tag);
    bit ok;
    if (use_b) begin b_valid = 1'b1; b_data = d; end
    else       begin a_valid = 1'b1; a_data = d; end
    wait_ready(use_b, ok);
    @(posedge clk); #1;
    a_valid = 1'b0;
    b_valid = 1'b0;
    if (ok) begin
      m_last_b = use_b;
      @(negedge clk);
      expect_write(tag, d);
      @(negedge clk);
      chk({tag, "_cur_row"}, cur_row, m_row);
      chk({tag, "_cur_col"}, cur_col, m_col);
    end
    @(posedge clk); #1;
  endtask

  task automatic check_image(input string tag);
    int diff = 0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (sh_mem[r][c] !== m_mem[r][c]) diff++;
    chk(tag, diff, 0);
  endtask

  initial begin
    bit ok, got, got_b;
    int n_a, n_b, cell_bad, nw;
    logic [7:0] d, p;

    reset = 1'b1; a_valid = 1'b0; b_valid = 1'b0; clr_req = 1'b0;
    a_data = 8'h00; b_data = 8'h00;
    m_row = HOME; m_col = 0; m_last_b = 1'b1;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        m_mem[r][c] = 8'h00;
    #2 reset = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_we", ram_we, 0);
    chk("rst_row", ram_row, 0);
    chk("rst_col", ram_col, 0);
    chk("rst_wdata", ram_wdata, 0);
    chk("rst_cur_row", cur_row, HOME);
    chk("rst_cur_col", cur_col, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", {a_ready, b_ready}, 0);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1;

    // 'H','I' back to back with valid held: one write every 2 clocks
    a_valid = 1'b1; a_data = 8'h48;
    wait_ready(1'b0, ok);
    @(posedge clk); #1 a_data = 8'h49;
    m_last_b = 1'b0;
    @(negedge clk);
    expect_write("t1_H", 8'h48);
    chk("t1_ready_in_write", a_ready, 0);
    @(negedge clk);
    chk("t1_gap_we", ram_we, 0);
    chk("t1_ready_idle", a_ready, 1);
    @(posedge clk); #1 a_valid = 1'b0;
    @(negedge clk);
    expect_write("t1_I", 8'h49);
    @(negedge clk);
    chk("t1_cur_row", cur_row, 1);
    chk("t1_cur_col", cur_col, 2);
    @(posedge clk); #1;

    // Column wrap at end of row
    for (int i = 0; i < 29; i++) send(1'($urandom_range(0, 1)), rnd_byte(), "t2_fill");
    chk("t2_pre_col", cur_col, 31);
    send(1'b0, 8'h58, "t2_X");
    chk("t2_X_row", cur_row, 2);
    chk("t2_X_col", cur_col, 0);

    // Newline, including bit 7 set, and full-screen wrap
    for (int i = 0; i < 5; i++) send(1'($urandom_range(0, 1)), rnd_byte(), "t3_fill");
    send(1'b0, 8'h7E, "t3_nl");
    chk("t3_nl_row", cur_row, 3);
    chk("t3_nl_col", cur_col, 0);
    for (int i = 0; i < 31; i++) send(1'($urandom_range(0, 1)), rnd_byte(), "t3_fill2");
    chk("t3_pre_wrap_col", cur_col, 31);
    send(1'b1, rnd_byte(), "t3_wrap");
    chk("t3_wrap_row", cur_row, 0);
    chk("t3_wrap_col", cur_col, 0);
    send(1'b0, 8'hFE, "t3_nl7");
    chk("t3_nl7_row", cur_row, 1);
    chk("t3_nl7_col", cur_col, 0);

    // Round robin with both sources held valid
    a_data = rnd_byte();
    b_data = rnd_byte();
    if (b_data == a_data) b_data = a_data ^ 8'h80;
    a_valid = 1'b1; b_valid = 1'b1;
    n_a = 0; n_b = 0;
    for (int k = 0; k < 8; k++) begin
      got = 1'b0;
      for (int i = 0; i < 10 && !got; i++) begin
        @(negedge clk);
        got = a_ready | b_ready;
      end
      chk("t4_one_ready", int'(a_ready) + int'(b_ready), 1);
      if (got) begin
        got_b = b_ready;
        chk("t4_grant_b", got_b, !m_last_b);
        d = got_b ? b_data : a_data;
        m_last_b = got_b;
        if (got_b) n_b++; else n_a++;
        @(posedge clk); #1;
        if (got_b) begin b_data = rnd_byte(); if (b_data == a_data) b_data = a_data ^ 8'h80; end
        else       begin a_data = rnd_byte(); if (a_data == b_data) a_data = b_data ^ 8'h80; end
        @(negedge clk);
        expect_write("t4_w", d);
      end
      if (k == 7) begin
        @(posedge clk); #1;
        a_valid = 1'b0; b_valid = 1'b0;
      end
    end
    chk("t4_count_a", n_a, 4);
    chk("t4_count_b", n_b, 4);
    @(negedge clk);
    chk("t4_cur_row", cur_row, m_row);
    chk("t4_cur_col", cur_col, m_col);
    @(posedge clk); #1;
    check_image("t4_image");

    // Clear wins over a pending byte; a second clr_req mid-sweep is ignored
    p = rnd_byte();
    clr_req = 1'b1; a_valid = 1'b1; a_data = p;
    @(negedge clk);
    chk("t5_ready_on_clr", {a_ready, b_ready}, 0);
    @(posedge clk); #1 clr_req = 1'b0;
    cell_bad = 0;
    for (int i = 0; i < CELLS; i++) begin
      @(negedge clk);
      if (ram_we !== 1'b1 || ram_row !== 2'(i / COLS) || ram_col !== 5'(i % COLS) ||
          ram_wdata !== 8'h20 || a_ready !== 1'b0 || b_ready !== 1'b0 || busy !== 1'b1)
        cell_bad++;
      if (i == 0)         chk("t5_first_cell", {ram_we, ram_row, ram_col}, {1'b1, 2'd0, 5'd0});
      if (i == CELLS - 1) chk("t5_last_cell", {ram_we, ram_row, ram_col}, {1'b1, 2'd3, 5'd31});
      clr_req = (i == 50);
    end
    clr_req = 1'b0;
    chk("t5_cells", cell_bad, 0);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        m_mem[r][c] = 8'h20;
    m_row = HOME; m_col = 0;
    @(negedge clk);
    chk("t5_end_we", ram_we, 0);
    chk("t5_cur_row", cur_row, 1);
    chk("t5_cur_col", cur_col, 0);
    chk("t5_pending_ready", a_ready, 1);
    @(posedge clk); #1 a_valid = 1'b0;
    m_last_b = 1'b0;
    @(negedge clk);
    expect_write("t5_pend", p);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_image("t5_image");

    // clr_req during WRITE, then reset in the middle of the sweep
    d = rnd_byte();
    a_valid = 1'b1; a_data = d;
    wait_ready(1'b0, ok);
    @(posedge clk); #1;
    a_valid = 1'b0; clr_req = 1'b1;
    m_last_b = 1'b0;
    @(negedge clk);
    expect_write("t6_w", d);
    @(posedge clk); #1;
    clr_req = 1'b0; a_valid = 1'b1; a_data = rnd_byte();
    @(negedge clk);
    chk("t6_pend_ready", a_ready, 0);
    chk("t6_pend_busy", busy, 1);
    cell_bad = 0;
    for (int i = 0; i <= 40; i++) begin
      @(negedge clk);
      if (ram_we !== 1'b1 || ram_row !== 2'(i / COLS) || ram_col !== 5'(i % COLS) ||
          ram_wdata !== 8'h20)
        cell_bad++;
      if (i < 40) m_mem[i / COLS][i % COLS] = 8'h20;
    end
    chk("t6_cells", cell_bad, 0);
    reset = 1'b0; a_valid = 1'b0;
    #1;
    chk("t6_rst_we", ram_we, 0);
    chk("t6_rst_cur_row", cur_row, 1);
    chk("t6_rst_cur_col", cur_col, 0);
    chk("t6_rst_busy", busy, 0);
    nw = n_writes;
    repeat (3) @(negedge clk);
    chk("t6_no_writes", n_writes - nw, 0);
    @(posedge clk); #1 reset = 1'b1;
    m_row = HOME; m_col = 0; m_last_b = 1'b1;
    @(posedge clk); #1;
    check_image("t6_image");
    send(1'b0, rnd_byte(), "t6_after");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
